// File: rtl/seq_fixed_multiplier.sv
// ---------------------------------------------------------------------------
// seq_fixed_multiplier
//   Sequential shift-add multiplier for unsigned fixed-point operands.
//   One multiplier bit is consumed per clock. The full 2*WIDTH-bit product is
//   accumulated, and the WIDTH-bit result is taken from it in the same
//   Q-format as the operands, truncated toward zero. Companion to the
//   restoring divider, so divider results can be scaled back.
//
// Parameters
//   WIDTH      operand/result width
//   FRAC_BITS  fractional bits in operands and result (0 <= FRAC_BITS < WIDTH)
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   start  request, sampled only in IDLE or DONE
//   in_a   multiplicand, captured when start is accepted
//   in_b   multiplier, captured when start is accepted
//   busy   high while iterating (CALC)
//   valid  one-cycle pulse when the result is presented (DONE)
//   q_out  result, held until the next completion or reset
//   ovf    product bits above the result field were non-zero, held with q_out
//
// Build option
//   MUL_ZERO_SKIP_EN  when defined, a zero operand completes in one cycle
//                     (straight to DONE with q_out=0, ovf=0, busy never set).
// ---------------------------------------------------------------------------
module seq_fixed_multiplier #(
    parameter int WIDTH     = 10,
    parameter int FRAC_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] q_out,
    output logic             ovf
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    // Product bits above the result field: 2W - (F + W) = W - F (always >= 1)
    localparam int HI_W  = WIDTH - FRAC_BITS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [WIDTH-1:0]     mplr;
    logic [CNT_W-1:0]     cnt;
    logic                 zero_op;

    // Accumulator value after this cycle's conditional add. The final CALC
    // cycle extracts the result from this so the last add is included.
    assign acc_sum = mplr[0] ? (acc + mcand) : acc;

`ifdef MUL_ZERO_SKIP_EN
    assign zero_op = (in_a == '0) || (in_b == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            valid <= 1'b0;
            q_out <= '0;
            ovf   <= 1'b0;
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mcand <= {{WIDTH{1'b0}}, in_a};
                        mplr  <= in_b;
                        acc   <= '0;
                        cnt   <= '0;
                        if (zero_op) begin
                            // Product is known to be zero: report it now.
                            state <= DONE;
                            busy  <= 1'b0;
                            valid <= 1'b1;
                            q_out <= '0;
                            ovf   <= 1'b0;
                        end else begin
                            state <= CALC;
                            busy  <= 1'b1;
                            valid <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                        valid <= 1'b0;
                    end
                end

                CALC: begin
                    // start is ignored here; nothing is queued.
                    acc   <= acc_sum;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        valid <= 1'b1;
                        q_out <= acc_sum[FRAC_BITS +: WIDTH];
                        ovf   <= |acc_sum[2*WIDTH-1 -: HI_W];
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_fixed_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_fixed_multiplier
//   Directed bench for seq_fixed_multiplier at WIDTH=10, FRAC_BITS=4.
//   Edge numbering: start is driven just after edge k, so it is sampled on
//   edge k+1; outputs are observed 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_seq_fixed_multiplier;

    localparam int WIDTH     = 10;
    localparam int FRAC_BITS = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] q_out;
    logic             ovf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_fixed_multiplier #(
        .WIDTH    (WIDTH),
        .FRAC_BITS(FRAC_BITS)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .in_a (in_a),
        .in_b (in_b),
        .busy (busy),
        .valid(valid),
        .q_out(q_out),
        .ovf  (ovf)
    );

    // Drives one operation starting after edge k; start stays high for edges
    // 1..hold-1 after k. Records first valid edge (relative to k), number of
    // valid pulses and number of busy cycles over n_edges edges.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int hold, input int n_edges,
                          output int first_v, output int v_cnt, output int b_cnt);
        @(posedge clk); #1;
        in_a = a; in_b = b; start = 1'b1;
        first_v = -1; v_cnt = 0; b_cnt = 0;
        for (int i = 1; i <= n_edges; i++) begin
            @(posedge clk); #1;
            if (i >= hold) start = 1'b0;
            if (valid) begin
                v_cnt++;
                if (first_v < 0) first_v = i;
            end
            if (busy) b_cnt++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; in_a = '0; in_b = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_checks++; if (q_out !== '0)   begin n_fail++; $display("FAIL reset_q: got %h want 000", q_out); end
        n_checks++; if (ovf !== 1'b0)   begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int fv, vc, bc;
        run_op(10'h018, 10'h020, 1, 20, fv, vc, bc);
        n_checks++; if (fv !== 11) begin n_fail++; $display("FAIL basic_latency: got edge %0d want 11", fv); end
        n_checks++; if (vc !== 1)  begin n_fail++; $display("FAIL basic_valid_count: got %0d want 1", vc); end
        n_checks++; if (bc !== 10) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 10", bc); end
        n_checks++; if (q_out !== 10'h030) begin n_fail++; $display("FAIL basic_q: got %h want 030", q_out); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_overflow;
        int fv, vc, bc, hold_err;
        run_op(10'h3FF, 10'h3FF, 1, 11, fv, vc, bc);
        n_checks++; if (fv !== 11) begin n_fail++; $display("FAIL ovf_latency: got edge %0d want 11", fv); end
        n_checks++; if (q_out !== 10'h380) begin n_fail++; $display("FAIL ovf_q: got %h want 380", q_out); end
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", ovf); end
        hold_err = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (q_out !== 10'h380 || ovf !== 1'b1 || valid !== 1'b0) hold_err++;
        end
        n_checks++; if (hold_err !== 0) begin n_fail++; $display("FAIL ovf_hold: got %0d bad cycles want 0", hold_err); end
    endtask

    task automatic test_zero_operand;
        int fv, vc, bc;
        run_op(10'h000, 10'h155, 1, 20, fv, vc, bc);
`ifdef MUL_ZERO_SKIP_EN
        n_checks++; if (fv !== 1) begin n_fail++; $display("FAIL zero_latency: got edge %0d want 1", fv); end
        n_checks++; if (bc !== 0) begin n_fail++; $display("FAIL zero_busy_cycles: got %0d want 0", bc); end
`else
        n_checks++; if (fv !== 11) begin n_fail++; $display("FAIL zero_latency: got edge %0d want 11", fv); end
        n_checks++; if (bc !== 10) begin n_fail++; $display("FAIL zero_busy_cycles: got %0d want 10", bc); end
`endif
        n_checks++; if (vc !== 1) begin n_fail++; $display("FAIL zero_valid_count: got %0d want 1", vc); end
        n_checks++; if (q_out !== '0) begin n_fail++; $display("FAIL zero_q: got %h want 000", q_out); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL zero_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_start_while_busy;
        int fv, vc;
        @(posedge clk); #1;
        in_a = 10'h010; in_b = 10'h010; start = 1'b1;
        fv = -1; vc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (i == 1) start = 1'b0;
            if (i == 3) begin start = 1'b1; in_a = 10'h3FF; in_b = 10'h3FF; end
            if (i == 4) start = 1'b0;
            if (valid) begin
                vc++;
                if (fv < 0) fv = i;
            end
        end
        n_checks++; if (fv !== 11) begin n_fail++; $display("FAIL busy_start_latency: got edge %0d want 11", fv); end
        n_checks++; if (vc !== 1)  begin n_fail++; $display("FAIL busy_start_valid_count: got %0d want 1", vc); end
        n_checks++; if (q_out !== 10'h010) begin n_fail++; $display("FAIL busy_start_q: got %h want 010", q_out); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL busy_start_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_back_to_back;
        int vc, q_err, busy37, stray;
        int vpos [3];
        vpos = '{-1, -1, -1};
        vc = 0; q_err = 0; busy37 = 0; stray = 0;
        @(posedge clk); #1;
        in_a = 10'h018; in_b = 10'h020; start = 1'b1;
        for (int i = 1; i <= 37; i++) begin
            @(posedge clk); #1;
            if (valid) begin
                if (vc < 3) vpos[vc] = i;
                vc++;
                if (q_out !== 10'h030) q_err++;
            end
            if (i == 37) busy37 = busy;
        end
        n_checks++; if (vc !== 3) begin n_fail++; $display("FAIL b2b_valid_count: got %0d want 3", vc); end
        n_checks++; if (vpos[0] !== 11) begin n_fail++; $display("FAIL b2b_valid0: got edge %0d want 11", vpos[0]); end
        n_checks++; if (vpos[1] !== 22) begin n_fail++; $display("FAIL b2b_valid1: got edge %0d want 22", vpos[1]); end
        n_checks++; if (vpos[2] !== 33) begin n_fail++; $display("FAIL b2b_valid2: got edge %0d want 33", vpos[2]); end
        n_checks++; if (q_err !== 0) begin n_fail++; $display("FAIL b2b_q: got %0d bad results want 0", q_err); end
        n_checks++; if (busy37 !== 1) begin n_fail++; $display("FAIL b2b_busy_mid: got %0d want 1", busy37); end

        // Reset lands mid-CALC with start still high; reset must win.
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", valid); end
        n_checks++; if (q_out !== '0)   begin n_fail++; $display("FAIL midrst_q: got %h want 000", q_out); end
        n_checks++; if (ovf !== 1'b0)   begin n_fail++; $display("FAIL midrst_ovf: got %b want 0", ovf); end
        rst = 1'b0; start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (valid || busy) stray++;
        end
        n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL midrst_no_valid: got %0d active cycles want 0", stray); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_overflow;
        test_zero_operand;
        test_start_while_busy;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
